// File: rtl/dvp_capture_pkg.sv
// Shared types and constants for the DVP pixel capture front end.
package dvp_capture_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SKIP   = 2'd1,
    SYNC   = 2'd2,
    ACTIVE = 2'd3
  } cap_state_e;

  localparam int unsigned PIX_BYTES_MIN = 1;
  localparam int unsigned PIX_BYTES_MAX = 3;

  // Beat counter width for a given number of beats per pixel.
  function automatic int unsigned beat_cnt_w(input int unsigned pix_bytes);
    return (pix_bytes > 1) ? $clog2(pix_bytes) : 1;
  endfunction

endpackage

// File: rtl/dvp_beat_packer.sv
// Collects PIX_BYTES bus beats into one pixel word, honouring the beat order swap.
module dvp_beat_packer
  import dvp_capture_pkg::*;
#(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned PIX_BYTES = 2
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        href,
  input  logic [DATA_W-1:0]           d,
  input  logic                        clear,
  input  logic                        swap,
  output logic [PIX_BYTES*DATA_W-1:0] word,
  output logic                        word_valid,
  output logic                        busy
);

  localparam int unsigned WORD_W = PIX_BYTES * DATA_W;
  localparam int unsigned BEAT_W = beat_cnt_w(PIX_BYTES);
  localparam int unsigned LAST   = PIX_BYTES - 1;

  logic [BEAT_W-1:0] beat_cnt;
  logic [WORD_W-1:0] acc;
  logic              last_beat;

  assign last_beat  = (beat_cnt == BEAT_W'(LAST));
  assign word_valid = href & ~clear & last_beat;
  assign busy       = (beat_cnt != '0);

  // Word as it stands with the current beat dropped into its slot.
  always_comb begin
    word = acc;
    for (int k = 0; k < int'(PIX_BYTES); k++) begin
      if (swap ? (32'(beat_cnt) == 32'(k)) : (32'(LAST) - 32'(beat_cnt) == 32'(k))) begin
        word[k*DATA_W +: DATA_W] = d;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_cnt <= '0;
      acc      <= '0;
    end else if (clear) begin
      beat_cnt <= '0;
    end else if (href) begin
      acc      <= word;
      beat_cnt <= last_beat ? '0 : beat_cnt + BEAT_W'(1);
    end
  end

endmodule

// File: rtl/dvp_pixel_capture.sv
// DVP camera capture front end: start-up frame skip, pixel assembly,
// x/y tagging with framing flags, and line/frame geometry checks.
module dvp_pixel_capture
  import dvp_capture_pkg::*;
#(
  parameter int unsigned DATA_W       = 8,
  parameter int unsigned PIX_BYTES    = 2,
  parameter int unsigned DUMMY_FRAMES = 10,
  parameter int unsigned H_ACTIVE     = 640,
  parameter int unsigned V_ACTIVE     = 480,
  parameter int unsigned CNT_W        = 12
) (
  input  logic                        cmos_pclk,
  input  logic                        rst_n,
  input  logic                        cmos_href,
  input  logic                        cmos_vsync,
  input  logic [DATA_W-1:0]           cmos_d,
  input  logic                        cfg_enable,
  input  logic                        cfg_swap,
  output logic [PIX_BYTES*DATA_W-1:0] pix_data,
  output logic                        pix_valid,
  output logic                        pix_sof,
  output logic                        pix_eol,
  output logic [CNT_W-1:0]            pix_x,
  output logic [CNT_W-1:0]            pix_y,
  output logic                        frame_done,
  output logic                        err_line,
  output logic                        err_frame,
  output logic [15:0]                 frame_cnt
);

  localparam int unsigned WORD_W    = PIX_BYTES * DATA_W;
  localparam int unsigned SKIP_W    = (DUMMY_FRAMES > 1) ? $clog2(DUMMY_FRAMES) : 1;
  localparam int unsigned SKIP_LAST = (DUMMY_FRAMES > 0) ? DUMMY_FRAMES - 1 : 0;
  localparam logic [CNT_W-1:0] H_MAX  = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_ACTIVE - 1);
  localparam logic [CNT_W-1:0] V_MAX  = CNT_W'(V_ACTIVE);

  if (PIX_BYTES < PIX_BYTES_MIN || PIX_BYTES > PIX_BYTES_MAX) begin : g_bad_pix_bytes
    $error("dvp_pixel_capture: PIX_BYTES must be 1..3");
  end

  cap_state_e        state, state_nxt;
  logic [SKIP_W-1:0] skip_cnt;
  logic              vsync_q, href_q;
  logic              vs_rise, href_fall;
  logic              active;
  logic              line_drop;
  logic              line_eval;
  logic [CNT_W-1:0]  x_cnt, y_cnt;
  logic              x_ovf, y_ovf;
  logic              sof_pend;
  logic              emit;

  logic [WORD_W-1:0] word;
  logic              word_valid, pk_busy, pk_href, pk_clear;

  assign vs_rise   = cmos_vsync & ~vsync_q;
  assign href_fall = ~cmos_href & href_q;
  assign active    = (state == ACTIVE);

  // A line cut by a vsync boundary is ignored until href goes low.
  assign pk_href   = active & cmos_href & ~vs_rise & ~line_drop;
  assign pk_clear  = ~active | vs_rise | href_fall;
  assign line_eval = active & href_fall & ~vs_rise & ~line_drop;
  assign emit      = word_valid & (x_cnt < H_MAX) & (y_cnt < V_MAX);

  dvp_beat_packer #(
    .DATA_W    (DATA_W),
    .PIX_BYTES (PIX_BYTES)
  ) u_packer (
    .clk        (cmos_pclk),
    .rst_n      (rst_n),
    .href       (pk_href),
    .d          (cmos_d),
    .clear      (pk_clear),
    .swap       (cfg_swap),
    .word       (word),
    .word_valid (word_valid),
    .busy       (pk_busy)
  );

  always_ff @(posedge cmos_pclk or negedge rst_n) begin
    if (!rst_n) begin
      vsync_q <= 1'b0;
      href_q  <= 1'b0;
    end else begin
      vsync_q <= cmos_vsync;
      href_q  <= cmos_href;
    end
  end

  always_ff @(posedge cmos_pclk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (cfg_enable) begin
          state_nxt = (DUMMY_FRAMES == 0) ? SYNC : SKIP;
        end
      end
      SKIP: begin
        if (!cfg_enable) begin
          state_nxt = IDLE;
        end else if (vs_rise && (skip_cnt == SKIP_W'(SKIP_LAST))) begin
          state_nxt = SYNC;
        end
      end
      SYNC: begin
        if (!cfg_enable) begin
          state_nxt = IDLE;
        end else if (vs_rise) begin
          state_nxt = ACTIVE;
        end
      end
      ACTIVE: begin
        // Disable only takes effect at a frame boundary.
        if (vs_rise && !cfg_enable) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge cmos_pclk or negedge rst_n) begin
    if (!rst_n) begin
      skip_cnt <= '0;
    end else if (state != SKIP) begin
      skip_cnt <= '0;
    end else if (vs_rise) begin
      skip_cnt <= skip_cnt + SKIP_W'(1);
    end
  end

  always_ff @(posedge cmos_pclk or negedge rst_n) begin
    if (!rst_n) begin
      line_drop <= 1'b0;
    end else if (!cmos_href) begin
      line_drop <= 1'b0;
    end else if (active && vs_rise) begin
      line_drop <= 1'b1;
    end
  end

  // Line/frame position; x and y saturate and flag overflow instead of wrapping.
  always_ff @(posedge cmos_pclk or negedge rst_n) begin
    if (!rst_n) begin
      x_cnt <= '0;
      x_ovf <= 1'b0;
      y_cnt <= '0;
      y_ovf <= 1'b0;
    end else if (!active || vs_rise) begin
      x_cnt <= '0;
      x_ovf <= 1'b0;
      y_cnt <= '0;
      y_ovf <= 1'b0;
    end else if (line_eval) begin
      x_cnt <= '0;
      x_ovf <= 1'b0;
      if ((x_cnt != '0) || x_ovf) begin
        if (y_cnt == V_MAX) begin
          y_ovf <= 1'b1;
        end else begin
          y_cnt <= y_cnt + CNT_W'(1);
        end
      end
    end else if (word_valid) begin
      if (x_cnt == H_MAX) begin
        x_ovf <= 1'b1;
      end else begin
        x_cnt <= x_cnt + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge cmos_pclk or negedge rst_n) begin
    if (!rst_n) begin
      sof_pend <= 1'b0;
    end else if (vs_rise && (state_nxt == ACTIVE)) begin
      sof_pend <= 1'b1;
    end else if (emit) begin
      sof_pend <= 1'b0;
    end
  end

  always_ff @(posedge cmos_pclk or negedge rst_n) begin
    if (!rst_n) begin
      pix_valid <= 1'b0;
      pix_data  <= '0;
      pix_x     <= '0;
      pix_y     <= '0;
      pix_sof   <= 1'b0;
      pix_eol   <= 1'b0;
    end else begin
      pix_valid <= emit;
      if (emit) begin
        pix_data <= word;
        pix_x    <= x_cnt;
        pix_y    <= y_cnt;
        pix_sof  <= sof_pend;
        pix_eol  <= (x_cnt == H_LAST);
      end
    end
  end

  // Geometry checks and frame accounting.
  always_ff @(posedge cmos_pclk or negedge rst_n) begin
    if (!rst_n) begin
      frame_done <= 1'b0;
      err_line   <= 1'b0;
      err_frame  <= 1'b0;
      frame_cnt  <= '0;
    end else begin
      frame_done <= active & vs_rise;
      err_frame  <= active & vs_rise & ((y_cnt != V_MAX) | y_ovf);
      err_line   <= (line_eval & ((x_cnt != H_MAX) | x_ovf | pk_busy)) |
                    (active & vs_rise & cmos_href);
      if (active && vs_rise) begin
        frame_cnt <= frame_cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_dvp_pixel_capture.sv
// Randomized directed bench for dvp_pixel_capture against a frame-level reference model.
module tb_dvp_pixel_capture;

  localparam int unsigned DW    = 8;
  localparam int unsigned PB    = 2;
  localparam int unsigned DUMMY = 2;
  localparam int unsigned H     = 8;
  localparam int unsigned V     = 4;
  localparam int unsigned CW    = 12;
  localparam int unsigned WW    = PB * DW;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          href, vsync, en, swap, en3;
  logic [DW-1:0] d;

  logic [WW-1:0] pix_data;
  logic          pix_valid, pix_sof, pix_eol, frame_done, err_line, err_frame;
  logic [CW-1:0] pix_x, pix_y;
  logic [15:0]   frame_cnt;

  logic [23:0]   pix_data3;
  logic          pix_valid3, pix_sof3, pix_eol3, frame_done3, err_line3, err_frame3;
  logic [CW-1:0] pix_x3, pix_y3;
  logic [15:0]   frame_cnt3;

  always #5 clk = ~clk;

  dvp_pixel_capture #(
    .DATA_W(DW), .PIX_BYTES(PB), .DUMMY_FRAMES(DUMMY),
    .H_ACTIVE(H), .V_ACTIVE(V), .CNT_W(CW)
  ) dut (
    .cmos_pclk(clk), .rst_n(rst_n), .cmos_href(href), .cmos_vsync(vsync),
    .cmos_d(d), .cfg_enable(en), .cfg_swap(swap),
    .pix_data(pix_data), .pix_valid(pix_valid), .pix_sof(pix_sof), .pix_eol(pix_eol),
    .pix_x(pix_x), .pix_y(pix_y), .frame_done(frame_done), .err_line(err_line),
    .err_frame(err_frame), .frame_cnt(frame_cnt)
  );

  dvp_pixel_capture #(
    .DATA_W(DW), .PIX_BYTES(3), .DUMMY_FRAMES(0),
    .H_ACTIVE(H), .V_ACTIVE(V), .CNT_W(CW)
  ) dut3 (
    .cmos_pclk(clk), .rst_n(rst_n), .cmos_href(href), .cmos_vsync(vsync),
    .cmos_d(d), .cfg_enable(en3), .cfg_swap(swap),
    .pix_data(pix_data3), .pix_valid(pix_valid3), .pix_sof(pix_sof3), .pix_eol(pix_eol3),
    .pix_x(pix_x3), .pix_y(pix_y3), .frame_done(frame_done3), .err_line(err_line3),
    .err_frame(err_frame3), .frame_cnt(frame_cnt3)
  );

  int vectors     = 0;
  int miscompares = 0;

  function automatic logic [63:0] pk(input logic [15:0] dd, input logic [11:0] x,
                                     input logic [11:0] y, input logic s, input logic e);
    return {22'd0, dd, x, y, s, e};
  endfunction

  // Output monitor, sampled on the falling edge.
  logic [63:0] got [0:1023];
  int          got_n      = 0;
  int          cnt_done   = 0;
  int          cnt_eline  = 0;
  int          cnt_eframe = 0;
  logic [23:0] got3 [0:7];
  int          got3_n     = 0;
  int          cnt_eline3 = 0;

  always @(negedge clk) begin
    if (pix_valid && got_n < 1024) begin
      got[got_n] = pk(pix_data, pix_x, pix_y, pix_sof, pix_eol);
      got_n++;
    end
    if (frame_done) cnt_done++;
    if (err_line)   cnt_eline++;
    if (err_frame)  cnt_eframe++;
    if (pix_valid3 && got3_n < 8) begin
      got3[got3_n] = pix_data3;
      got3_n++;
    end
    if (err_line3) cnt_eline3++;
  end

  // Reference model state
  int          m_rises  = 0;
  bit          m_active = 1'b0;
  int          m_lines  = 0;
  bit          m_sof    = 1'b0;
  int          e_done   = 0;
  int          e_eline  = 0;
  int          e_eframe = 0;
  int          e_fcnt   = 0;
  logic [63:0] exp_q [$];
  int          rd       = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    vectors++;
    assert (obs === exp_v) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Frame boundary: the captured frame (if any) closes, skip/sync progress otherwise.
  task automatic model_rise();
    if (m_active) begin
      e_done++;
      e_fcnt = (e_fcnt + 1) & 16'hFFFF;
      if (m_lines != int'(V)) e_eframe++;
      m_active = en;
      m_rises  = 0;
    end else if (en) begin
      m_rises++;
      if (m_rises > int'(DUMMY)) m_active = 1'b1;
    end else begin
      m_rises = 0;
    end
    m_lines = 0;
    m_sof   = 1'b1;
  endtask

  task automatic vs_pulse();
    @(negedge clk);
    vsync = 1'b1;
    model_rise();
    cyc(3);
    vsync = 1'b0;
    cyc(4);
  endtask

  task automatic send_line(input int beats);
    logic [7:0]  b [0:31];
    logic [15:0] dd;
    int          npix, part;
    for (int i = 0; i < beats; i++) b[i] = 8'($urandom);
    if (m_active) begin
      npix = beats / int'(PB);
      part = beats % int'(PB);
      for (int p = 0; p < npix; p++) begin
        if (p < int'(H) && m_lines < int'(V)) begin
          dd = swap ? {b[2*p+1], b[2*p]} : {b[2*p], b[2*p+1]};
          exp_q.push_back(pk(dd, 12'(p), 12'(m_lines), m_sof, p == int'(H) - 1));
          m_sof = 1'b0;
        end
      end
      if (npix != int'(H) || part != 0) e_eline++;
      if (npix > 0) m_lines++;
    end
    for (int i = 0; i < beats; i++) begin
      @(negedge clk);
      href = 1'b1;
      d    = b[i];
    end
    @(negedge clk);
    href = 1'b0;
    d    = 8'($urandom);
    cyc(4);
  endtask

  task automatic send_lines(input int n, input int beats);
    for (int l = 0; l < n; l++) send_line(beats);
  endtask

  task automatic check_all(input string tag);
    cyc(2);
    while (exp_q.size() > 0 && rd < got_n) begin
      chk({tag, ".pixel"}, got[rd], exp_q.pop_front());
      rd++;
    end
    chk({tag, ".pixel_count"}, 64'(got_n), 64'(rd + exp_q.size()));
    exp_q.delete();
    rd = got_n;
    chk({tag, ".frame_done"}, 64'(cnt_done), 64'(e_done));
    chk({tag, ".err_line"}, 64'(cnt_eline), 64'(e_eline));
    chk({tag, ".err_frame"}, 64'(cnt_eframe), 64'(e_eframe));
    chk({tag, ".frame_cnt"}, 64'(frame_cnt), 64'(e_fcnt));
  endtask

  function automatic logic [63:0] all_outputs();
    return 64'({pix_valid, pix_sof, pix_eol, frame_done, err_line, err_frame,
                pix_data, pix_x, pix_y, frame_cnt});
  endfunction

  initial begin
    // Reset with input activity
    rst_n = 1'b0; href = 1'b0; vsync = 1'b0; d = '0; en = 1'b0; en3 = 1'b0; swap = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      href  = 1'($urandom);
      vsync = 1'($urandom);
      d     = 8'($urandom);
    end
    chk("reset.outputs", all_outputs(), 64'd0);
    chk("reset.outputs3", 64'({pix_valid3, pix_data3, frame_cnt3}), 64'd0);
    @(negedge clk);
    href = 1'b0; vsync = 1'b0;
    rst_n = 1'b1;
    cyc(3);

    // Three-beat pixels on the second instance while the main one stays disabled
    en3 = 1'b1;
    cyc(2);
    vs_pulse();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      href = 1'b1;
      d    = 8'(17 * (i + 1));
    end
    @(negedge clk);
    href = 1'b0;
    cyc(4);
    en3 = 1'b0;
    chk("pb3.count", 64'(got3_n), 64'd2);
    chk("pb3.pixel0", 64'(got3[0]), 64'h112233);
    chk("pb3.pixel1", 64'(got3[1]), 64'h445566);
    chk("pb3.err_line", 64'(cnt_eline3), 64'd1);
    send_lines(2, 16);
    check_all("disabled");

    // Start-up skip then a clean frame
    en = 1'b1;
    cyc(2);
    vs_pulse(); send_lines(4, 16);
    vs_pulse(); send_lines(4, 16);
    check_all("skip");
    vs_pulse(); send_lines(4, 16);
    check_all("cap1");

    // Line geometry with swapped beat order
    swap = 1'b1;
    vs_pulse();
    send_line(14); send_line(17); send_line(18); send_line(16);
    check_all("line_geom");
    swap = 1'b0;

    // Short and long frames
    vs_pulse(); send_lines(3, 16);
    check_all("short_frame");
    vs_pulse(); send_lines(5, 16);
    check_all("long_frame");

    // Disable mid-frame: frame completes, then idle
    vs_pulse();
    send_lines(2, 16);
    en = 1'b0;
    send_lines(2, 16);
    check_all("disable_mid");
    vs_pulse(); send_lines(4, 16);
    check_all("idle_after_disable");
    vs_pulse();

    // Re-enable, capture, then reset mid-frame
    en = 1'b1;
    cyc(2);
    vs_pulse(); send_lines(4, 16);
    vs_pulse(); send_lines(4, 16);
    vs_pulse(); send_lines(4, 16);
    vs_pulse(); send_lines(2, 16);
    check_all("reenable");
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_reset.outputs", all_outputs(), 64'd0);
    m_active = 1'b0; m_rises = 0; m_lines = 0; e_fcnt = 0; exp_q.delete();
    cyc(3);
    rst_n = 1'b1;
    cyc(2);
    rd = got_n;
    vs_pulse(); send_lines(4, 16);
    vs_pulse(); send_lines(4, 16);
    check_all("post_reset_skip");
    swap = 1'($urandom);
    vs_pulse(); send_lines(4, 16);
    vs_pulse();
    check_all("post_reset_cap");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
